mips_fetch_stage: RTL and testbench
===================================

// Module: mips_fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of MIPS_core's decode/ALU path.
//  Holds the PC and a word-addressed instruction memory preloadable by the bench.
//  Presents one registered instruction per cycle with its PC, valid flag and PC+4.
//  Supports decode stall, branch/jump redirect and a sticky fetch fault.
// PARAMETERS
//  IMEM_DEPTH  64            instruction memory depth in 32-bit words (power of 2, >=4)
//  RESET_PC    32'h00000000  PC value loaded on reset
// PORTS
//  clock           in   1   system clock, all state updates on posedge
//  reset           in   1   asynchronous, active-high reset
//  load_en         in   1   write enable for instruction memory preload (BOOT only)
//  load_addr       in   32  byte address for preload; word index = load_addr[31:2]
//  load_data       in   32  instruction word written at load_addr
//  stall           in   1   downstream not ready: hold PC and all outputs
//  redirect_valid  in   1   take branch/jump this cycle
//  redirect_pc     in   32  target byte address for redirect
//  instr           out  32  fetched instruction (32'h0 = NOP when invalid)
//  instr_pc        out  32  byte address instr was fetched from
//  pc_plus4        out  32  instr_pc + 4, modulo 2^32
//  instr_valid     out  1   instr/instr_pc/pc_plus4 hold a real instruction
//  fault           out  1   sticky: misaligned or out-of-range fetch occurred
// BEHAVIOUR
//  Reset (async, any time, incl. mid-run): state=BOOT, pc=RESET_PC, instr=0,
//   instr_pc=0, pc_plus4=0, instr_valid=0, fault=0. Memory contents are NOT cleared.
//  States: BOOT, RUN, FAULT.
//  BOOT: load_en=1 -> mem[load_addr[31:2] mod IMEM_DEPTH] <= load_data, stay BOOT.
//   load_en=0 -> go RUN next cycle. stall and redirect ignored. Outputs stay reset values.
//  RUN (evaluated each posedge, priority order):
//   1. redirect_valid=1: pc<=redirect_pc; instr_valid<=0; instr<=0 (one-cycle bubble);
//      beats stall if both asserted.
//   2. stall=1: pc and all outputs hold their values.
//   3. else fetch check on current pc: pc[1:0]!=0 or pc[31:2]>=IMEM_DEPTH
//      -> state FAULT, fault<=1, instr_valid<=0, instr<=0, pc holds.
//   4. else instr<=mem[pc[31:2]], instr_pc<=pc, pc_plus4<=pc+4,
//      instr_valid<=1, pc<=pc+4 (wraps mod 2^32).
//   load_en ignored in RUN.
//  Latency: one cycle from pc to instr output; sustained 1 instr/cycle when unstalled.
//  A misaligned redirect_pc is accepted into pc and faults on the next fetch attempt.
//  FAULT: terminal until reset; fault=1, instr_valid=0, all inputs ignored.
//  Memory read is synchronous to fetch; no read/write overlap (writes BOOT-only).
// TESTING
//  T1 reset: assert reset mid-RUN asynchronously -> outputs zero, fault=0
//     immediately; memory preserved (refetch after release returns same words).
//  T2 preload mem[0..3]=32'h20080005,20090003,01095020,AC0A0000, release load_en
//     -> instr_valid rises; instr_pc 0,4,8,12 with matching words on successive cycles.
//  T3 stall 3 cycles while instr_pc=4 -> instr, instr_pc, pc_plus4=8 held;
//     fetch resumes with instr_pc=8.
//  T4 redirect_valid+stall together with redirect_pc=32'h0 at instr_pc=8
//     -> next cycle instr_valid=0, instr=0; following cycle instr_pc=0.
//  T5 redirect_pc=32'h6 -> bubble, then fault=1, instr_valid=0, stays latched
//     despite further redirects until reset.
//  T6 run sequentially to pc=4*IMEM_DEPTH (256 at default)
//     -> last valid instr_pc=252, then fault=1.

Source files
------------

// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch: PC, preloadable word memory, one registered instruction per cycle.
// One-cycle pc->instr latency; stall holds everything, redirect wins over stall and inserts a bubble.
module mips_fetch_stage #(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        fault
);

   localparam int AW = $clog2(IMEM_DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        instr_valid_q, instr_valid_d;
   logic        fault_q, fault_d;

   logic [31:0] mem [IMEM_DEPTH];
   logic        fetch_bad;
   logic        unused_load_bits;

   // Preload aliases modulo the depth, so only the index bits matter.
   assign unused_load_bits = ^{load_addr[1:0], load_addr[31:AW+2]};

   assign fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= 30'(IMEM_DEPTH));

   always_ff @(posedge clock) begin
      if (state_q == BOOT && load_en) begin
         mem[load_addr[AW+1:2]] <= load_data;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      pc_plus4_d    = pc_plus4_q;
      instr_valid_d = instr_valid_q;
      fault_d       = fault_q;
      case (state_q)
         BOOT: begin
            if (!load_en) state_d = RUN;
         end
         RUN: begin
            if (redirect_valid) begin
               pc_d          = redirect_pc;
               instr_d       = 32'h0;
               instr_valid_d = 1'b0;
            end else if (stall) begin
               state_d = RUN;
            end else if (fetch_bad) begin
               state_d       = FAULT;
               fault_d       = 1'b1;
               instr_d       = 32'h0;
               instr_valid_d = 1'b0;
            end else begin
               instr_d       = mem[pc_q[AW+1:2]];
               instr_pc_d    = pc_q;
               pc_plus4_d    = pc_q + 32'd4;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + 32'd4;
            end
         end
         default: begin
            state_d = FAULT;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0;
         instr_pc_q    <= 32'h0;
         pc_plus4_q    <= 32'h0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         pc_plus4_q    <= pc_plus4_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign pc_plus4    = pc_plus4_q;
   assign instr_valid = instr_valid_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: preload, sequential fetch, stall, redirect, fault and reset.
module tb_mips_fetch_stage;

   localparam int DEPTH = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        fault;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp_mem [DEPTH];
   int          passed = 0;
   int          total  = 0;

   mips_fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .instr(instr), .instr_pc(instr_pc),
      .pc_plus4(pc_plus4), .instr_valid(instr_valid), .fault(fault)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_fetch(input logic [31:0] pc);
      exp_t e;
      e.instr = exp_mem[pc[31:2] % DEPTH];
      e.pc    = pc;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b1; load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      step(); step();
      total++;
      if ({instr, instr_pc, pc_plus4, instr_valid, fault} !== {96'h0, 2'b00})
         $display("FAIL reset_outputs: got instr=%h pc=%h p4=%h v=%b f=%b, want all zero",
                  instr, instr_pc, pc_plus4, instr_valid, fault);
      else passed++;
   endtask

   task automatic test_preload();
      exp_t e;
      load_en = 1'b1;
      reset   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         load_addr = i * 4;
         load_data = exp_mem[i];
         step();
         total++;
         if (instr_valid !== 1'b0 || instr !== 32'h0) begin
            $display("FAIL boot_quiet[%0d]: got v=%b instr=%h, want v=0 instr=0", i, instr_valid, instr);
         end else passed++;
      end
      load_en = 1'b0;
      step();
      total++;
      if (instr_valid !== 1'b0) $display("FAIL boot_to_run: got v=%b, want 0", instr_valid);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         push_fetch(i * 4);
         step();
         e = sb.pop_front();
         total++;
         if (instr_valid !== 1'b1 || instr !== e.instr || instr_pc !== e.pc || pc_plus4 !== e.pc + 32'd4)
            $display("FAIL preload_fetch[%0d]: got v=%b instr=%h pc=%h p4=%h, want v=1 instr=%h pc=%h p4=%h",
                     i, instr_valid, instr, instr_pc, pc_plus4, e.instr, e.pc, e.pc + 32'd4);
         else passed++;
      end
   endtask

   task automatic test_reset_midrun();
      exp_t e;
      #3;
      reset = 1'b1;
      #1;
      total++;
      if ({instr, instr_pc, pc_plus4, instr_valid, fault} !== {96'h0, 2'b00})
         $display("FAIL async_reset: got instr=%h pc=%h p4=%h v=%b f=%b, want all zero",
                  instr, instr_pc, pc_plus4, instr_valid, fault);
      else passed++;
      step();
      reset = 1'b0;
      step();
      for (int i = 0; i < 2; i++) begin
         push_fetch(i * 4);
         step();
         e = sb.pop_front();
         total++;
         if (instr_valid !== 1'b1 || instr !== e.instr || instr_pc !== e.pc)
            $display("FAIL refetch_after_reset[%0d]: got v=%b instr=%h pc=%h, want v=1 instr=%h pc=%h",
                     i, instr_valid, instr, instr_pc, e.instr, e.pc);
         else passed++;
      end
   endtask

   task automatic test_stall();
      exp_t e;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (instr_valid !== 1'b1 || instr !== exp_mem[1] || instr_pc !== 32'd4 || pc_plus4 !== 32'd8)
            $display("FAIL stall_hold[%0d]: got v=%b instr=%h pc=%h p4=%h, want v=1 instr=%h pc=4 p4=8",
                     i, instr_valid, instr, instr_pc, pc_plus4, exp_mem[1]);
         else passed++;
      end
      stall = 1'b0;
      push_fetch(32'd8);
      step();
      e = sb.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr !== e.instr || instr_pc !== e.pc)
         $display("FAIL stall_resume: got v=%b instr=%h pc=%h, want v=1 instr=%h pc=%h",
                  instr_valid, instr, instr_pc, e.instr, e.pc);
      else passed++;
   endtask

   task automatic test_redirect_stall();
      exp_t e;
      redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h0;
      step();
      redirect_valid = 1'b0; stall = 1'b0;
      total++;
      if (instr_valid !== 1'b0 || instr !== 32'h0)
         $display("FAIL redirect_bubble: got v=%b instr=%h, want v=0 instr=0", instr_valid, instr);
      else passed++;
      push_fetch(32'h0);
      step();
      e = sb.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr !== e.instr || instr_pc !== e.pc || pc_plus4 !== 32'd4)
         $display("FAIL redirect_target: got v=%b instr=%h pc=%h p4=%h, want v=1 instr=%h pc=%h p4=4",
                  instr_valid, instr, instr_pc, pc_plus4, e.instr, e.pc);
      else passed++;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   bad = 0;
      for (int pc = 4; pc < 4 * DEPTH; pc += 4) begin
         push_fetch(pc);
         step();
         e = sb.pop_front();
         total++;
         if (instr_valid !== 1'b1 || instr !== e.instr || instr_pc !== e.pc || pc_plus4 !== e.pc + 32'd4) begin
            bad++;
            if (bad < 5)
               $display("FAIL seq_fetch: got v=%b instr=%h pc=%h p4=%h, want v=1 instr=%h pc=%h p4=%h",
                        instr_valid, instr, instr_pc, pc_plus4, e.instr, e.pc, e.pc + 32'd4);
         end else passed++;
      end
      step();
      total++;
      if (fault !== 1'b1 || instr_valid !== 1'b0 || instr_pc !== 32'd252)
         $display("FAIL range_fault: got f=%b v=%b pc=%h, want f=1 v=0 pc=fc", fault, instr_valid, instr_pc);
      else passed++;
   endtask

   task automatic test_misaligned_fault();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      step();
      step();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || fault !== 1'b0)
         $display("FAIL mis_prefetch: got v=%b pc=%h f=%b, want v=1 pc=0 f=0", instr_valid, instr_pc, fault);
      else passed++;
      redirect_valid = 1'b1; redirect_pc = 32'h6;
      step();
      redirect_valid = 1'b0;
      total++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || fault !== 1'b0)
         $display("FAIL mis_bubble: got v=%b instr=%h f=%b, want v=0 instr=0 f=0", instr_valid, instr, fault);
      else passed++;
      step();
      total++;
      if (fault !== 1'b1 || instr_valid !== 1'b0)
         $display("FAIL mis_fault: got f=%b v=%b, want f=1 v=0", fault, instr_valid);
      else passed++;
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (fault !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL fault_sticky[%0d]: got f=%b v=%b, want f=1 v=0", i, fault, instr_valid);
         else passed++;
      end
      redirect_valid = 1'b0;
      reset = 1'b1;
      #1;
      total++;
      if (fault !== 1'b0 || instr_valid !== 1'b0)
         $display("FAIL fault_clear: got f=%b v=%b, want f=0 v=0", fault, instr_valid);
      else passed++;
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] prog [4];
      prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0003;
      prog[2] = 32'h0109_5020; prog[3] = 32'hAC0A_0000;
      for (int i = 0; i < DEPTH; i++)
         exp_mem[i] = (i < 4) ? prog[i] : 32'hA500_0000 + i * 32'h0001_0101;
      test_reset();
      test_preload();
      test_reset_midrun();
      test_stall();
      test_redirect_stall();
      test_back_to_back();
      test_misaligned_fault();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
